// File: rtl/jtag_port_pkg.sv
// Shared definitions for the parametrised JTAG debug port: TAP state encodings,
// instruction opcodes and the IDCODE constant.
package jtag_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_ISEL   = 3'b001,
        ST_DSHFT  = 3'b010,
        ST_ISHFT  = 3'b100,
        ST_DSEL   = 3'b101,
        ST_UPDATE = 3'b110
    } tap_state_t;

    localparam logic [2:0] OP_SET_ADDR = 3'b001;
    localparam logic [2:0] OP_MEM_RD   = 3'b010;
    localparam logic [2:0] OP_MEM_WR   = 3'b011;
    localparam logic [2:0] OP_ACCESS   = 3'b100;
    localparam logic [2:0] OP_IDCODE   = 3'b111;

    localparam logic [31:0] IDCODE = 32'h0000_5C11;

endpackage

// File: rtl/jtag_tap_fsm.sv
// Reduced TAP controller: 3-bit state register plus next-state decode, exposing
// the DSHFT/UPDATE phases and the status-load strobe on the ISEL->ISHFT edge.
module jtag_tap_fsm
    import jtag_port_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic tms,
    output logic in_dshft_c,
    output logic in_update_c,
    output logic load_status_c
);

    tap_state_t state;
    tap_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Unused encodings (011, 111) fall through to IDLE.
    always_comb begin
        state_nxt     = ST_IDLE;
        in_dshft_c    = 1'b0;
        in_update_c   = 1'b0;
        load_status_c = 1'b0;
        case (state)
            ST_IDLE:   state_nxt = tms ? ST_ISEL : ST_IDLE;
            ST_ISEL: begin
                state_nxt     = tms ? ST_DSEL : ST_ISHFT;
                load_status_c = !tms;
            end
            ST_ISHFT:  state_nxt = tms ? ST_UPDATE : ST_ISHFT;
            ST_DSEL:   state_nxt = tms ? ST_IDLE : ST_DSHFT;
            ST_DSHFT: begin
                state_nxt  = tms ? ST_IDLE : ST_DSHFT;
                in_dshft_c = 1'b1;
            end
            ST_UPDATE: begin
                state_nxt   = ST_IDLE;
                in_update_c = 1'b1;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/jtag_port_gen.sv
// Parametrised JTAG debug port: instruction/data shift registers, memory access,
// access-channel select and TDO mux. Optional IDCODE op enabled by JTAG_IDCODE_EN.
module jtag_port_gen
    import jtag_port_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CMD_W   = 8,
    parameter int unsigned NUM_ACC = 2
) (
    input  logic                i_TCK,
    input  logic                i_rstn,
    input  logic                i_TMS,
    input  logic                i_TDI,
    output logic                o_TDO,
    input  logic                i_isBooted,
    input  logic                i_isPaused,
    input  logic [DATA_W-1:0]   i_memDataIn,
    output logic [ADDR_W-1:0]   o_memAddr,
    output logic [DATA_W-1:0]   o_memDataOut,
    output logic                o_memWr,
    output logic                o_memEn,
    input  logic [NUM_ACC-1:0]  i_accTDO,
    output logic [NUM_ACC-1:0]  o_access
);

    localparam int unsigned ARG_W = CMD_W - 3;

    logic               in_dshft_c;
    logic               in_update_c;
    logic               load_status_c;

    logic [CMD_W-1:0]   cmd;
    logic [DATA_W-1:0]  data;
    logic [ADDR_W-1:0]  addr;
    logic [NUM_ACC-1:0] sel;

    logic [2:0]         op;
    logic [ARG_W-1:0]   arg;
    logic               set_addr_c;
    logic               mem_ok_c;
    logic               acc_ok_c;
    logic [NUM_ACC-1:0] sel_nxt_c;
    logic               tdo_c;

    jtag_tap_fsm u_fsm (
        .clk           (i_TCK),
        .rst_n         (i_rstn),
        .tms           (i_TMS),
        .in_dshft_c    (in_dshft_c),
        .in_update_c   (in_update_c),
        .load_status_c (load_status_c)
    );

    assign op  = cmd[2:0];
    assign arg = cmd[CMD_W-1:3];

    // Instruction decode; only acted upon while in UPDATE.
    always_comb begin
        set_addr_c = (op == OP_SET_ADDR) && (arg == '0);
        mem_ok_c   = ((op == OP_MEM_RD) || (op == OP_MEM_WR))
                     && ((arg & ~ARG_W'(1)) == '0) && i_isPaused;
        acc_ok_c   = (op == OP_ACCESS) && i_isPaused
                     && (arg != '0) && (arg <= ARG_W'(NUM_ACC));
        sel_nxt_c  = '0;
        if (acc_ok_c) begin
            sel_nxt_c = NUM_ACC'(1) << (arg - ARG_W'(1));
        end
    end

    // Command register shifts on every edge except the status load.
    always_ff @(posedge i_TCK or negedge i_rstn) begin
        if (!i_rstn) begin
            cmd <= '0;
        end else if (load_status_c) begin
            cmd <= CMD_W'({i_isPaused, i_isBooted});
        end else begin
            cmd <= {cmd[CMD_W-2:0], i_TDI};
        end
    end

    always_ff @(posedge i_TCK or negedge i_rstn) begin
        if (!i_rstn) begin
            data <= '0;
        end else if (in_dshft_c) begin
            data <= {data[DATA_W-2:0], i_TDI};
        end else if (in_update_c && mem_ok_c && (op == OP_MEM_RD)) begin
            data <= i_memDataIn;
`ifdef JTAG_IDCODE_EN
        end else if (in_update_c && (op == OP_IDCODE) && (arg == '0)) begin
            data <= DATA_W'(IDCODE);
`endif
        end
    end

    // Address changes only on the UPDATE exit edge; increment wraps naturally.
    always_ff @(posedge i_TCK or negedge i_rstn) begin
        if (!i_rstn) begin
            addr <= '0;
        end else if (in_update_c) begin
            if (set_addr_c) begin
                addr <= data[ADDR_W-1:0];
            end else if (mem_ok_c && arg[0]) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_TCK or negedge i_rstn) begin
        if (!i_rstn) begin
            sel <= '0;
        end else if (in_update_c) begin
            sel <= sel_nxt_c;
        end
    end

    always_comb begin
        tdo_c = cmd[CMD_W-1];
        if (in_dshft_c) begin
            tdo_c = (|sel) ? (|(i_accTDO & sel)) : data[DATA_W-1];
        end
    end

    assign o_TDO        = tdo_c;
    assign o_memEn      = in_update_c && mem_ok_c;
    assign o_memWr      = in_update_c && mem_ok_c && cmd[0];
    assign o_memAddr    = addr;
    assign o_memDataOut = data;
    assign o_access     = sel & {NUM_ACC{in_dshft_c}};

endmodule

// File: doc/jtag_port_gen.md
Name: jtag_port_gen

Overview:
- Parametrised successor of the debug JTAG port: parses TCK/TMS/TDI into a 3-bit state machine, an instruction shift register and a data shift register.
- Executes address-set, runtime memory read/write (with optional post-increment) and N-way access-channel selection.
- Muxes TDO internally between its own shift registers and the selected access channel's TDO.
- Sits between the JTAG pins and the memory arbiter / SPI / scan-chain blocks.

Parameters:
- DATA_W, 16, data shift register and memory data width
- ADDR_W, 16, address register width; ADDR_W <= DATA_W is required
- CMD_W, 8, instruction register width; CMD_W >= 4 is required
- NUM_ACC, 2, number of access channels (1..2^(CMD_W-3)-1)

Ports:
- i_TCK  in  1  JTAG clock; the only clock; all state updates on its rising edge
- i_rstn  in  1  asynchronous, active-low reset
- i_TMS  in  1  JTAG mode select
- i_TDI  in  1  JTAG data in
- o_TDO  out  1  JTAG data out
- i_isBooted  in  1  uP boot status
- i_isPaused  in  1  uP paused (true PAUSED only)
- i_memDataIn  in  DATA_W  memory read data; combinational, valid while o_memEn is high
- o_memAddr  out  ADDR_W  address register
- o_memDataOut  out  DATA_W  data register
- o_memWr  out  1  1 = write, 0 = read
- o_memEn  out  1  memory strobe
- i_accTDO  in  NUM_ACC  TDO from each access channel
- o_access  out  NUM_ACC  one-hot channel enable (shift/chip select)

Behaviour:
- State encoding: IDLE=000, ISEL=001, DSHFT=010, ISHFT=100, DSEL=101, UPDATE=110. Encodings 011 and 111 go to IDLE.
- Transitions:
  - IDLE: TMS=1 -> ISEL, else stay.
  - ISEL: TMS=0 -> ISHFT, TMS=1 -> DSEL.
  - ISHFT: TMS=0 -> stay, TMS=1 -> UPDATE.
  - DSEL: TMS=0 -> DSHFT, TMS=1 -> IDLE.
  - DSHFT: TMS=0 -> stay, TMS=1 -> IDLE.
  - UPDATE: -> IDLE unconditionally.
- CMD register:
  - On the ISEL->ISHFT edge it loads the status word {0..., i_isPaused, i_isBooted}.
  - Every other edge it left-shifts in TDI. This includes ISHFT and DSHFT, so the command is whatever was shifted last.
- DATA register:
  - Left-shifts TDI only in DSHFT.
  - Loads i_memDataIn in UPDATE when MEM_RD executes.
  - Otherwise holds.
- Command decode: op = cmd[2:0], arg = cmd[CMD_W-1:3]. All decode is evaluated only in UPDATE.
  - 001 SET_ADDR, requires arg=0: addr <= data[ADDR_W-1:0]. Not gated by pause.
  - 010 MEM_RD / 011 MEM_WR: arg[0] = post-increment, other arg bits must be 0. Requires i_isPaused. o_memEn=1 and o_memWr=cmd[0] combinationally during UPDATE. RD captures i_memDataIn into data at the UPDATE exit edge. If arg[0]=1, addr <= addr+1 at the same edge, modulo 2^ADDR_W (all-ones wraps to 0).
  - 100 ACCESS: requires i_isPaused. arg=k with 1<=k<=NUM_ACC selects access register bit k-1. Any other arg selects none.
  - Any other op, or a nonzero illegal arg: no action.
- Access select register:
  - Rewritten on every UPDATE: one-hot for a valid ACCESS, all zeros otherwise.
  - o_access = sel & {NUM_ACC{inDSHFT}}.
  - An ACCESS issued while not paused clears any previous selection.
- TDO mux:
  - In DSHFT with a channel selected: i_accTDO[k-1].
  - In DSHFT with no channel selected: data[DATA_W-1].
  - Otherwise: cmd[CMD_W-1].
- Non-DSHFT strobes: o_memEn is 0 outside UPDATE. Address changes only at UPDATE exit.
- Reset (asynchronous, any time including mid-shift or UPDATE):
  - state=IDLE; cmd, data, addr and sel = 0.
  - Outputs: o_TDO=0, o_memEn=0, o_memWr=0, o_access=0, o_memAddr=0, o_memDataOut=0.
  - A command in flight is discarded.

Optional Feature:
- JTAG_IDCODE_EN defined: op 111 with arg=0 loads the constant IDCODE into data in UPDATE, regardless of pause. The value is zero-extended or truncated to DATA_W (16'h5C11 at default). The following DSHFT shifts it out MSB first.
- Undefined: op 111 is no action.

Decomposition:
- Package jtag_port_pkg:
  - state encodings
  - opcode constants (OP_SET_ADDR, OP_MEM_RD, OP_MEM_WR, OP_ACCESS, OP_IDCODE)
  - IDCODE constant
- Sub-module jtag_tap_fsm:
  - state register plus next-state logic
  - outputs inDSHFT, inUPDATE and loadStatus
- The remaining logic (registers, decode, muxing) stays in the top.

Test Plan:
- Reset: assert i_rstn=0 mid-DSHFT -> all outputs 0 immediately, state IDLE. After release, TDO=0.
- Status readout: isBooted=1, isPaused=1, enter ISHFT -> first 8 TDO bits are 0000_0011.
- Set address: shift data 16'h1234, cmd 8'h01, UPDATE -> o_memAddr=16'h1234. Repeat with isPaused=0 -> address still updates.
- Write with auto-increment: paused, addr=16'hFFFF, cmd 8'h0B, data 16'hBEEF -> memEn=1 and memWr=1 for one TCK in UPDATE, memDataOut=BEEF. Then addr=16'h0000 (wrap). Repeat with isPaused=0 -> memEn stays 0, addr unchanged.
- Read: paused, mem returns 16'hA5A5, cmd 8'h02 -> next DSHFT shifts A5A5 MSB first on TDO, memWr=0.
- Access select: paused, cmd 8'h14 (k=2) -> in DSHFT o_access=2'b10 and TDO follows i_accTDO[1]. Then cmd 8'h0C (k=1) with isPaused=0 -> o_access stays 0 after that UPDATE.
